dcache_ctrl: RTL and testbench

- Blocking, direct-mapped, write-back, write-allocate data cache between the MEM/WB-stage load/store port and a line-wide main-memory port.
- It is the producer of the DCacheMiss stall request that the hazard unit consumes.
- While `miss` is high, the pipeline holds the request stable. The controller fetches the line, writing back the victim first if it is dirty, then completes the access as a hit.

---
 rtl/dcache_pkg.sv | 27 ++
 rtl/dcache_mem_model.sv | 54 +++++
 rtl/dcache_ctrl.sv | 136 +++++++++++++
 tb/tb_dcache_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// dcache_pkg: shared constants and types for the direct-mapped data cache.
//   Address layout (byte address): [1:0] byte, then word offset, set index, tag.
//   state_e: refill FSM states of dcache_ctrl.
package dcache_pkg;

   localparam int unsigned LINE_ADDR_LEN = 3;  // log2 words per line
   localparam int unsigned SET_ADDR_LEN  = 3;  // log2 number of sets
   localparam int unsigned TAG_ADDR_LEN  = 6;

   localparam int unsigned MEM_ADDR_LEN = TAG_ADDR_LEN + SET_ADDR_LEN;  // line address width
   localparam int unsigned LINE_W       = 32 << LINE_ADDR_LEN;
   localparam int unsigned LINE_WORDS   = 1 << LINE_ADDR_LEN;
   localparam int unsigned NUM_SETS     = 1 << SET_ADDR_LEN;

   localparam int unsigned OFF_LSB = 2;
   localparam int unsigned SET_LSB = OFF_LSB + LINE_ADDR_LEN;
   localparam int unsigned TAG_LSB = SET_LSB + SET_ADDR_LEN;
   localparam int unsigned TAG_MSB = TAG_LSB + TAG_ADDR_LEN - 1;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      SWAP_OUT   = 2'd1,
      SWAP_IN    = 2'd2,
      SWAP_IN_OK = 2'd3
   } state_e;

endpackage

// File: rtl/dcache_mem_model.sv
// dcache_mem_model: line-wide main memory with a programmable grant delay.
//   clk, rst          : clock, asynchronous active-high reset (delay counter only)
//   rd_req, wr_req    : line read / write-back request, held until gnt
//   addr              : line address
//   wr_line, rd_line  : write-back data in, fetched line out (combinational)
//   gnt               : one-cycle completion pulse, after `delay` wait cycles
//   ld_en/ld_addr/ld_line : preload port, takes priority over write-back
module dcache_mem_model
   import dcache_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    rd_req,
   input  logic                    wr_req,
   input  logic [MEM_ADDR_LEN-1:0] addr,
   input  logic [LINE_W-1:0]       wr_line,
   output logic [LINE_W-1:0]       rd_line,
   output logic                    gnt,
   input  logic [3:0]              delay,
   input  logic                    ld_en,
   input  logic [MEM_ADDR_LEN-1:0] ld_addr,
   input  logic [LINE_W-1:0]       ld_line
);

   localparam int unsigned DEPTH = 1 << MEM_ADDR_LEN;

   logic [LINE_W-1:0] mem_q [DEPTH];
   logic [3:0]        cnt_q;
   logic              req;

   assign req     = rd_req || wr_req;
   assign gnt     = req && (cnt_q == delay);
   assign rd_line = mem_q[addr];

   // Counts wait cycles of the current request; restarts once granted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= 4'd0;
      end else if (!req || gnt) begin
         cnt_q <= 4'd0;
      end else begin
         cnt_q <= cnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (ld_en) begin
         mem_q[ld_addr] <= ld_line;
      end else if (gnt && wr_req) begin
         mem_q[addr] <= wr_line;
      end
   end

endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: blocking, direct-mapped, write-back, write-allocate data cache.
//   clk, rst              : clock, asynchronous active-high reset
//   addr, rd_req, wr_req, wr_data : pipeline load/store port (held while miss)
//   rd_data               : load word, combinational
//   miss                  : stall request to the hazard unit
//   hit_count, miss_count : wrapping event counters
//   mem_rd_req, mem_wr_req, mem_addr, mem_wr_line, mem_rd_line, mem_gnt : line memory port
module dcache_ctrl
   import dcache_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [31:0]             addr,
   input  logic                    rd_req,
   input  logic                    wr_req,
   input  logic [31:0]             wr_data,
   output logic [31:0]             rd_data,
   output logic                    miss,
   output logic [31:0]             hit_count,
   output logic [31:0]             miss_count,
   output logic                    mem_rd_req,
   output logic                    mem_wr_req,
   output logic [MEM_ADDR_LEN-1:0] mem_addr,
   output logic [LINE_W-1:0]       mem_wr_line,
   input  logic [LINE_W-1:0]       mem_rd_line,
   input  logic                    mem_gnt
);

   logic [LINE_W-1:0]       line_q [NUM_SETS];
   logic [TAG_ADDR_LEN-1:0] tag_q  [NUM_SETS];
   logic [NUM_SETS-1:0]     valid_q, dirty_q;
   logic [LINE_W-1:0]       buf_q;
   logic [31:0]             hit_cnt_q, miss_cnt_q;
   state_e                  state_q, state_d;

   logic [LINE_ADDR_LEN-1:0] off;
   logic [SET_ADDR_LEN-1:0]  set;
   logic [TAG_ADDR_LEN-1:0]  tag;
   logic                     req, hit, hit_now, miss_now, store_now, refill;
   logic [31:0]              cur_word;
   logic                     unused_addr;

   assign off         = addr[OFF_LSB +: LINE_ADDR_LEN];
   assign set         = addr[SET_LSB +: SET_ADDR_LEN];
   assign tag         = addr[TAG_LSB +: TAG_ADDR_LEN];
   assign unused_addr = ^{addr[31:TAG_MSB+1], addr[1:0]};

   assign req       = rd_req || wr_req;
   assign hit       = valid_q[set] && (tag_q[set] == tag);
   assign hit_now   = (state_q == IDLE) && req && hit;
   assign miss_now  = (state_q == IDLE) && req && !hit;
   assign store_now = hit_now && wr_req;
   assign refill    = (state_q == SWAP_IN_OK);

   assign cur_word = line_q[set][{off, 5'd0} +: 32];
   // With rd_req and wr_req both high this is still the pre-write word.
   assign rd_data  = rd_req ? cur_word : 32'd0;
   // Gated by rst so the stall drops immediately on an asynchronous reset.
   assign miss     = !rst && ((state_q != IDLE) || (req && !hit));

   assign hit_count  = hit_cnt_q;
   assign miss_count = miss_cnt_q;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:       if (miss_now) state_d = (valid_q[set] && dirty_q[set]) ? SWAP_OUT : SWAP_IN;
         SWAP_OUT:   if (mem_gnt) state_d = SWAP_IN;
         SWAP_IN:    if (mem_gnt) state_d = SWAP_IN_OK;
         SWAP_IN_OK: state_d = IDLE;
         default:    state_d = IDLE;
      endcase
   end

   // Memory-port outputs
   always_comb begin
      mem_rd_req  = 1'b0;
      mem_wr_req  = 1'b0;
      mem_addr    = '0;
      mem_wr_line = '0;
      case (state_q)
         SWAP_OUT: begin
            mem_wr_req  = 1'b1;
            mem_addr    = {tag_q[set], set};
            mem_wr_line = line_q[set];
         end
         SWAP_IN: begin
            mem_rd_req = 1'b1;
            mem_addr   = {tag, set};
         end
         default: ;
      endcase
   end

   // Control state: line status bits, counters, refill buffer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q    <= '0;
         dirty_q    <= '0;
         hit_cnt_q  <= 32'd0;
         miss_cnt_q <= 32'd0;
         buf_q      <= '0;
      end else begin
         if (hit_now)  hit_cnt_q  <= hit_cnt_q + 32'd1;
         if (miss_now) miss_cnt_q <= miss_cnt_q + 32'd1;
         if ((state_q == SWAP_IN) && mem_gnt) buf_q <= mem_rd_line;
         if (refill) begin
            valid_q[set] <= 1'b1;
            dirty_q[set] <= 1'b0;
         end else if (store_now) begin
            dirty_q[set] <= 1'b1;
         end
      end
   end

   // Line data and tags are qualified by valid_q, so they carry no reset.
   always_ff @(posedge clk) begin
      if (refill) begin
         line_q[set] <= buf_q;
         tag_q[set]  <= tag;
      end else if (store_now) begin
         line_q[set][{off, 5'd0} +: 32] <= wr_data;
      end
   end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed bench for dcache_ctrl backed by dcache_mem_model.
module tb_dcache_ctrl;
   import dcache_pkg::*;

   logic                    clk = 1'b0;
   logic                    rst;
   logic [31:0]             addr, wr_data, rd_data, hit_count, miss_count;
   logic                    rd_req, wr_req, miss;
   logic                    mem_rd_req, mem_wr_req, mem_gnt, model_gnt;
   logic [MEM_ADDR_LEN-1:0] mem_addr, ld_addr;
   logic [LINE_W-1:0]       mem_wr_line, mem_rd_line, ld_line;
   logic                    ld_en, use_model, force_gnt;
   logic [3:0]              mem_delay;

   int checks = 0;
   int errors = 0;

   // Memory-port activity, accumulated at each negedge
   int                      rd_cycles = 0, wr_cycles = 0;
   logic [MEM_ADDR_LEN-1:0] rd_addr_seen, wr_addr_seen;
   logic [LINE_W-1:0]       wr_line_seen;

   always #5 clk = ~clk;

   assign mem_gnt = use_model ? model_gnt : force_gnt;

   dcache_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .addr        (addr),
      .rd_req      (rd_req),
      .wr_req      (wr_req),
      .wr_data     (wr_data),
      .rd_data     (rd_data),
      .miss        (miss),
      .hit_count   (hit_count),
      .miss_count  (miss_count),
      .mem_rd_req  (mem_rd_req),
      .mem_wr_req  (mem_wr_req),
      .mem_addr    (mem_addr),
      .mem_wr_line (mem_wr_line),
      .mem_rd_line (mem_rd_line),
      .mem_gnt     (mem_gnt)
   );

   dcache_mem_model u_mem (
      .clk     (clk),
      .rst     (rst),
      .rd_req  (mem_rd_req),
      .wr_req  (mem_wr_req),
      .addr    (mem_addr),
      .wr_line (mem_wr_line),
      .rd_line (mem_rd_line),
      .gnt     (model_gnt),
      .delay   (mem_delay),
      .ld_en   (ld_en),
      .ld_addr (ld_addr),
      .ld_line (ld_line)
   );

   always @(negedge clk) begin
      if (mem_rd_req) begin
         rd_cycles++;
         rd_addr_seen = mem_addr;
      end
      if (mem_wr_req) begin
         wr_cycles++;
         wr_addr_seen = mem_addr;
         wr_line_seen = mem_wr_line;
      end
      assert (!(mem_rd_req && mem_wr_req)) else begin
         errors++;
         $error("FAIL mem_req_excl: observed rd=%0b wr=%0b required not both", mem_rd_req,
                mem_wr_req);
      end
   end

   // Request must not change while the previous cycle was stalled
   logic        prev_miss = 1'b0, prev_rd = 1'b0, prev_wr = 1'b0;
   logic [31:0] prev_addr = '0, prev_data = '0;
   always @(posedge clk) begin
      if (!rst && prev_miss) begin
         assert ({addr, rd_req, wr_req, wr_data} === {prev_addr, prev_rd, prev_wr, prev_data})
         else begin
            errors++;
            $error("FAIL req_stable: observed addr=%0h required addr=%0h", addr, prev_addr);
         end
      end
      prev_miss = miss;
      prev_addr = addr;
      prev_rd   = rd_req;
      prev_wr   = wr_req;
      prev_data = wr_data;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish required finish before 200000");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   task automatic load(input logic [MEM_ADDR_LEN-1:0] la, input logic [31:0] w0,
                       input logic [31:0] w1);
      logic [LINE_W-1:0] l;
      for (int i = 0; i < int'(LINE_WORDS); i++) l[i*32 +: 32] = 32'hA5A5_0000 + i;
      l[31:0]  = w0;
      l[63:32] = w1;
      ld_addr = la;
      ld_line = l;
      ld_en   = 1'b1;
      @(posedge clk);
      #1 ld_en = 1'b0;
   endtask

   // Called at posedge+1; returns the number of cycles miss was high (detection cycle included)
   // and rd_data in the completing hit cycle.
   task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, output int mcyc, output logic [31:0] rdata);
      logic timeout = 1'b1;
      addr    = a;
      rd_req  = rd;
      wr_req  = wr;
      wr_data = d;
      mcyc    = 0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (!miss) begin
            timeout = 1'b0;
            break;
         end
         mcyc++;
      end
      rdata = rd_data;
      chk("timeout", {63'd0, timeout}, 64'd0);
      @(posedge clk);
      #1;
      rd_req = 1'b0;
      wr_req = 1'b0;
   endtask

   int          m, r0, w0;
   logic [31:0] rd;

   initial begin
      rst = 1'b1;
      addr = '0; rd_req = 1'b0; wr_req = 1'b0; wr_data = '0;
      ld_en = 1'b0; ld_addr = '0; ld_line = '0;
      use_model = 1'b1; force_gnt = 1'b0; mem_delay = 4'd0;

      load(9'h002, 32'hDEAD_BEEF, 32'hCAFE_F00D);
      load(9'h042, 32'h0BAD_F00D, 32'h1111_2222);
      load(9'h003, 32'h3333_3333, 32'h0);
      load(9'h005, 32'h5555_5555, 32'h0);

      // Reset state
      @(negedge clk);
      chk("rst_miss", {63'd0, miss}, 64'd0);
      chk("rst_hits", hit_count, 0);
      chk("rst_misses", miss_count, 0);
      chk("rst_mem_req", {mem_rd_req, mem_wr_req}, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rd_data_idle", rd_data, 0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Cold start: clean miss, stall = cycles after the detection cycle
      r0 = rd_cycles;
      access(1'b1, 1'b0, 32'h40, 32'h0, m, rd);
      chk("cold_stall", m - 1, 2);
      chk("cold_rd_cycles", rd_cycles - r0, 1);
      chk("cold_mem_addr", rd_addr_seen, 9'h002);
      chk("cold_rd_data", rd, 32'hDEAD_BEEF);
      chk("cold_misses", miss_count, 1);
      chk("cold_hits", hit_count, 1);

      // Hit path
      access(1'b1, 1'b0, 32'h44, 32'h0, m, rd);
      chk("hit_nomiss", m, 0);
      chk("hit_rd_data", rd, 32'hCAFE_F00D);
      chk("hit_hits", hit_count, 2);

      // Dirty eviction
      access(1'b0, 1'b1, 32'h40, 32'h1234_5678, m, rd);
      chk("store_nomiss", m, 0);
      w0 = wr_cycles;
      access(1'b1, 1'b0, 32'h840, 32'h0, m, rd);
      chk("evict_wr_cycles", wr_cycles - w0, 1);
      chk("evict_wr_addr", wr_addr_seen, 9'h002);
      chk("evict_wr_word0", wr_line_seen[31:0], 32'h1234_5678);
      chk("evict_rd_addr", rd_addr_seen, 9'h042);
      chk("evict_stall", m - 1, 3);
      chk("evict_rd_data", rd, 32'h0BAD_F00D);
      chk("evict_misses", miss_count, 2);
      chk("evict_hits", hit_count, 4);

      // Written-back data comes back; victim was clean so no write-back
      w0 = wr_cycles;
      access(1'b1, 1'b0, 32'h40, 32'h0, m, rd);
      chk("refetch_rd_data", rd, 32'h1234_5678);
      chk("refetch_no_wb", wr_cycles - w0, 0);
      chk("refetch_misses", miss_count, 3);

      // Simultaneous read+write on a hit
      access(1'b1, 1'b1, 32'h44, 32'h55AA_55AA, m, rd);
      chk("rw_nomiss", m, 0);
      chk("rw_old_word", rd, 32'hCAFE_F00D);
      access(1'b1, 1'b0, 32'h44, 32'h0, m, rd);
      chk("rw_new_word", rd, 32'h55AA_55AA);
      w0 = wr_cycles;
      access(1'b1, 1'b0, 32'h844, 32'h0, m, rd);
      chk("rw_dirty_wb", wr_cycles - w0, 1);
      chk("rw_wb_word1", wr_line_seen[63:32], 32'h55AA_55AA);
      chk("rw_rd_data", rd, 32'h1111_2222);
      chk("rw_misses", miss_count, 4);
      chk("rw_hits", hit_count, 8);

      // Slow memory, clean miss
      mem_delay = 4'd5;
      r0 = rd_cycles;
      access(1'b1, 1'b0, 32'h60, 32'h0, m, rd);
      chk("slow_stall", m - 1, 7);
      chk("slow_rd_cycles", rd_cycles - r0, 6);
      chk("slow_mem_addr", rd_addr_seen, 9'h003);
      chk("slow_rd_data", rd, 32'h3333_3333);
      chk("slow_misses", miss_count, 5);
      chk("slow_hits", hit_count, 9);
      mem_delay = 4'd0;

      // Reset mid-refill, then a stray grant
      use_model = 1'b0;
      addr = 32'hA0;
      rd_req = 1'b1;
      @(negedge clk);
      chk("mid_detect_miss", {63'd0, miss}, 1);
      @(negedge clk);
      chk("mid_swap_in_req", {63'd0, mem_rd_req}, 1);
      chk("mid_swap_in_addr", mem_addr, 9'h005);
      #2;
      rst = 1'b1;
      rd_req = 1'b0;
      #1;
      chk("mid_rst_req", {mem_rd_req, mem_wr_req}, 0);
      chk("mid_rst_addr", mem_addr, 0);
      chk("mid_rst_miss", {63'd0, miss}, 0);
      chk("mid_rst_misses", miss_count, 0);
      chk("mid_rst_hits", hit_count, 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1 force_gnt = 1'b1;
      @(negedge clk);
      chk("late_gnt_req", {mem_rd_req, mem_wr_req}, 0);
      chk("late_gnt_miss", {63'd0, miss}, 0);
      @(posedge clk);
      #1 force_gnt = 1'b0;
      @(negedge clk);
      chk("late_gnt_idle", {mem_rd_req, mem_wr_req}, 0);
      use_model = 1'b1;
      @(posedge clk);
      #1;
      access(1'b1, 1'b0, 32'hA0, 32'h0, m, rd);
      chk("reread_stall", m - 1, 2);
      chk("reread_rd_data", rd, 32'h5555_5555);
      chk("reread_misses", miss_count, 1);
      chk("reread_hits", hit_count, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
